imem_boot_loader: RTL and testbench



---
 rtl/imem_boot_loader_pkg.sv | 18 +
 rtl/imem_boot_loader_byte_writer.sv | 54 +++++
 rtl/imem_boot_loader.sv | 175 +++++++++++++++++
 tb/tb_imem_boot_loader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared FSM state encoding and error codes for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    LDR_LEN_HI,
    LDR_LEN_LO,
    LDR_DATA,
    LDR_CSUM,
    LDR_DONE,
    LDR_ERROR
  } ldr_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/imem_boot_loader_byte_writer.sv
// Registered instruction-memory write port plus the running byte counter and
// 8-bit additive checksum of the payload.
module ldr_byte_writer
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_i,
  input  logic              wr_i,
  input  logic [7:0]        data_i,
  output logic [ADDR_W:0]   count_o,
  output logic [7:0]        checksum_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o
);

  logic [ADDR_W:0]   count_q;
  logic [7:0]        csum_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;

  // Counter is one bit wider than the address so a full-capacity frame never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      csum_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= wr_i;
      if (clear_i) begin
        count_q <= '0;
        csum_q  <= '0;
      end else if (wr_i) begin
        count_q     <= count_q + (ADDR_W+1)'(1);
        csum_q      <= csum_q + data_i;
        mem_addr_q  <= count_q[ADDR_W-1:0];
        mem_wdata_q <= data_i;
      end
    end
  end

  assign count_o     = count_q;
  assign checksum_o  = csum_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader for the instruction memory; holds the core in reset
// until a frame loads with a good checksum. Optional idle timeout: LOADER_TIMEOUT_EN.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W         = 11,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_reset_n,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

  ldr_state_e      state_q;
  logic [7:0]      len_hi_q;
  logic [ADDR_W:0] total_q;
  logic            in_ready_q;
  logic            core_reset_n_q;
  logic            done_q;
  logic            error_q;
  logic [1:0]      err_code_q;

  logic            accept;
  logic            wr_data;
  logic            clear_cnt;
  logic            last_byte;
  logic            timeout_hit;
  logic            fault;
  logic [1:0]      fault_code;
  logic [31:0]     req_bytes;
  logic [ADDR_W:0] byte_cnt;
  logic [7:0]      checksum;

  assign accept    = in_valid && in_ready_q;
  assign req_bytes = {14'd0, len_hi_q, in_data, 2'b00};
  assign wr_data   = accept && (state_q == LDR_DATA);
  assign clear_cnt = accept && (state_q == LDR_LEN_LO);
  assign last_byte = (byte_cnt + (ADDR_W+1)'(1)) == total_q;

  ldr_byte_writer #(.ADDR_W(ADDR_W)) u_writer (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (clear_cnt),
    .wr_i        (wr_data),
    .data_i      (in_data),
    .count_o     (byte_cnt),
    .checksum_o  (checksum),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata)
  );

`ifdef LOADER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_q;
  logic              idle_active;

  // LEN_HI is excluded so the loader can wait indefinitely for a frame start.
  assign idle_active = (state_q == LDR_LEN_LO) || (state_q == LDR_DATA) || (state_q == LDR_CSUM);
  assign timeout_hit = idle_active && !accept && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_q <= '0;
    end else if (!idle_active || accept) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + IDLE_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    fault      = 1'b0;
    fault_code = ERR_NONE;
    if (accept && (state_q == LDR_LEN_LO) && (req_bytes > CAPACITY)) begin
      fault      = 1'b1;
      fault_code = ERR_LEN;
    end else if (accept && (state_q == LDR_CSUM) && (in_data != checksum)) begin
      fault      = 1'b1;
      fault_code = ERR_CSUM;
    end else if (timeout_hit) begin
      fault      = 1'b1;
      fault_code = ERR_TIMEOUT;
    end
  end

  // The case handles the good path; any fault overrides it afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= LDR_LEN_HI;
      len_hi_q       <= '0;
      total_q        <= '0;
      in_ready_q     <= 1'b0;
      core_reset_n_q <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      err_code_q     <= ERR_NONE;
    end else begin
      case (state_q)
        LDR_LEN_HI: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            len_hi_q <= in_data;
            state_q  <= LDR_LEN_LO;
          end
        end
        LDR_LEN_LO: begin
          if (accept) begin
            total_q <= req_bytes[ADDR_W:0];
            state_q <= (req_bytes == 32'd0) ? LDR_CSUM : LDR_DATA;
          end
        end
        LDR_DATA: begin
          if (accept && last_byte) begin
            state_q <= LDR_CSUM;
          end
        end
        LDR_CSUM: begin
          if (accept) begin
            state_q        <= LDR_DONE;
            in_ready_q     <= 1'b0;
            done_q         <= 1'b1;
            core_reset_n_q <= 1'b1;
          end
        end
        LDR_DONE, LDR_ERROR: begin
          if (load_req) begin
            state_q        <= LDR_LEN_HI;
            in_ready_q     <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            err_code_q     <= ERR_NONE;
            core_reset_n_q <= 1'b0;
          end
        end
        default: state_q <= LDR_LEN_HI;
      endcase

      if (fault) begin
        state_q        <= LDR_ERROR;
        in_ready_q     <= 1'b0;
        done_q         <= 1'b0;
        error_q        <= 1'b1;
        err_code_q     <= fault_code;
        core_reset_n_q <= 1'b0;
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign core_reset_n = core_reset_n_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: random framed streams against a frame-level
// reference model; build with +define+LOADER_TIMEOUT_EN to exercise the idle timeout.
module tb_imem_boot_loader;

  localparam int ADDR_W   = 11;
  localparam int TIMEOUT  = 16;
  localparam int CAPACITY = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              load_req = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              core_reset_n;
  logic              done;
  logic              error;
  logic [1:0]        err_code;

  int     checkCount = 0;
  int     errorCount = 0;
  longint cyc = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    longint            when;
  } wr_t;

  wr_t               expQ[$];
  wr_t               got;
  logic [ADDR_W-1:0] lastAddr = '0;

  imem_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .load_req     (load_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_reset_n (core_reset_n),
    .done         (done),
    .error        (error),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every memory write must match the oldest expected write, including its cycle.
  always @(negedge clk) begin
    if (reset_n && mem_we) begin
      checkCount++;
      if (expQ.size() == 0) begin
        errorCount++;
        $display("[TB] FAIL unexpected_write got addr=%h data=%h expected no write", mem_addr, mem_wdata);
      end else begin
        got = expQ.pop_front();
        if (mem_addr !== got.addr || mem_wdata !== got.data || cyc != got.when) begin
          errorCount++;
          $display("[TB] FAIL mem_write got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                   mem_addr, mem_wdata, cyc, got.addr, got.data, got.when);
        end
      end
      lastAddr = mem_addr;
    end
  end

  // Frame-level reference: {done, error, err_code, core_reset_n, in_ready} after the frame.
  function automatic logic [5:0] modelStatus(input logic [7:0] f[$]);
    int n;
    int sum;
    n = int'({f[0], f[1]});
    if (4 * n > CAPACITY) return 6'b0_1_01_0_0;
    sum = 0;
    for (int i = 0; i < 4 * n; i++) sum += int'(f[2 + i]);
    if (f[2 + 4 * n] == 8'(sum)) return 6'b1_0_00_1_0;
    return 6'b0_1_10_0_0;
  endfunction

  task automatic buildFrame(input int n, input bit corrupt, output logic [7:0] f[$]);
    int sum;
    f = {};
    f.push_back(8'(n >> 8));
    f.push_back(8'(n));
    sum = 0;
    for (int i = 0; i < 4 * n; i++) begin
      f.push_back(8'($urandom_range(255)));
      sum += int'(f[f.size() - 1]);
    end
    if (corrupt) sum += 1 + int'($urandom_range(254));
    f.push_back(8'(sum));
  endtask

  task automatic sendByte(input logic [7:0] b, input int gapPct, input bit isData, input int addr);
    int guard;
    if (gapPct > 0 && int'($urandom_range(99)) < gapPct) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom_range(255));
      repeat ($urandom_range(3, 1)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (in_ready !== 1'b1) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL handshake_wait got in_ready=%b expected 1", in_ready);
      in_valid = 1'b0;
    end else begin
      if (isData) expQ.push_back('{ADDR_W'(addr), b, cyc + 1});
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] f[$], input int gapPct, input int first, input int last);
    int n;
    bit lenOk;
    n     = int'({f[0], f[1]});
    lenOk = (4 * n <= CAPACITY);
    for (int i = first; i <= last; i++)
      sendByte(f[i], gapPct, lenOk && i >= 2 && i < 2 + 4 * n, i - 2);
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [5:0] expected);
    logic [5:0] actual;
    actual = {done, error, err_code, core_reset_n, in_ready};
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s got {done,error,err_code,core_reset_n,in_ready}=%b expected %b", name, actual, expected);
    end
  endtask

  task automatic checkValue(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic restartLoad();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    checkOutput("restart", 6'b0_0_00_0_1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [7:0] f[$];

    #12;
    checkOutput("reset_status", 6'b0_0_00_0_0);
    checkValue("reset_mem_port", longint'({mem_we, mem_addr, mem_wdata}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_len_hi", 6'b0_0_00_0_1);

    // Directed good frame, back-to-back.
    f = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    applyStimulus(f, 0, 0, f.size() - 1);
    checkOutput("good_frame", modelStatus(f));
    checkValue("good_frame_drained", expQ.size(), 0);

    // Directed checksum mismatch.
    restartLoad();
    f = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    applyStimulus(f, 0, 0, f.size() - 1);
    checkOutput("bad_csum", modelStatus(f));
    checkValue("bad_csum_drained", expQ.size(), 0);

    // Length one word beyond capacity.
    restartLoad();
    f = '{8'h02, 8'h01};
    applyStimulus(f, 0, 0, 1);
    checkOutput("len_overflow", modelStatus(f));
    repeat (4) @(negedge clk);
    checkOutput("len_overflow_held", modelStatus(f));

    // Empty frame, then restart clears status.
    restartLoad();
    f = '{8'h00, 8'h00, 8'h00};
    applyStimulus(f, 0, 0, 2);
    checkOutput("empty_frame", modelStatus(f));
    restartLoad();

    // Full-capacity frame with random gaps.
    buildFrame(CAPACITY / 4, 1'b0, f);
    applyStimulus(f, 30, 0, f.size() - 1);
    checkOutput("full_frame", modelStatus(f));
    checkValue("full_last_addr", longint'(lastAddr), CAPACITY - 1);
    checkValue("full_drained", expQ.size(), 0);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkValue("done_ignores_bytes", longint'(in_ready), 0);
    end
    in_valid = 1'b0;
    checkOutput("done_held", 6'b1_0_00_1_0);

    // Stall inside DATA.
    restartLoad();
    buildFrame(1, 1'b0, f);
    applyStimulus(f, 0, 0, 3);
    repeat (TIMEOUT - 1) @(negedge clk);
    checkOutput("stall_before_limit", 6'b0_0_00_0_1);
    @(negedge clk);
`ifdef LOADER_TIMEOUT_EN
    checkOutput("stall_timeout", 6'b0_1_11_0_0);
    checkValue("stall_drained", expQ.size(), 0);
`else
    checkOutput("stall_waiting", 6'b0_0_00_0_1);
    applyStimulus(f, 0, 4, f.size() - 1);
    checkOutput("stall_resumed", modelStatus(f));
    checkValue("stall_drained", expQ.size(), 0);
`endif

    // Asynchronous reset in the middle of DATA.
    restartLoad();
    buildFrame(2, 1'b0, f);
    applyStimulus(f, 0, 0, 4);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset", 6'b0_0_00_0_0);
    checkValue("async_reset_mem_port", longint'({mem_we, mem_addr, mem_wdata}), 0);
    checkValue("async_reset_drained", expQ.size(), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("after_reset", 6'b0_0_00_0_1);

    // Random frames, some with corrupted checksums.
    for (int k = 0; k < 4; k++) begin
      buildFrame(int'($urandom_range(8, 1)), ($urandom_range(3) == 0), f);
      applyStimulus(f, 20, 0, f.size() - 1);
      checkOutput("random_frame", modelStatus(f));
      checkValue("random_drained", expQ.size(), 0);
      restartLoad();
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
